// File: rtl/wb_nor_arbiter.sv
// ============================================================================
// wb_nor_arbiter : two-master Wishbone arbiter in front of nor_bus, with a
//                  per-cycle grant and a no-progress watchdog.
// Optional feature macro: WB_NOR_ARB_RR_EN (round-robin; fixed priority if unset)
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_nor_arbiter #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  // master 0 (QSPI command path)
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic                m0_err_i,
  input  logic [ADDRBITS-1:0] m0_adr_i,
  input  logic [DATABITS-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_stall_o,
  output logic [DATABITS-1:0] m0_dat_o,
  // master 1 (scrub/scan engine)
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic                m1_err_i,
  input  logic [ADDRBITS-1:0] m1_adr_i,
  input  logic [DATABITS-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_stall_o,
  output logic [DATABITS-1:0] m1_dat_o,
  // shared nor_bus port
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic                s_err_o,
  output logic [ADDRBITS-1:0] s_adr_o,
  output logic [DATABITS-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_stall_i,
  input  logic [DATABITS-1:0] s_dat_i,
  // debug
  output logic [1:0]          gnt_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state;
  logic   flush_m;     // which master was revoked by the watchdog
  logic   pick1;       // master 1 wins the IDLE decision
  logic   wdog_fire;
  logic   g0;
  logic   g1;

  assign g0 = (state == GNT0);
  assign g1 = (state == GNT1);

`ifdef WB_NOR_ARB_RR_EN
  logic last;
  assign pick1 = m1_cyc_i & (~m0_cyc_i | ~last);
`else
  assign pick1 = m1_cyc_i & ~m0_cyc_i;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      gnt_o     <= 2'b00;
      timeout_o <= 1'b0;
      flush_m   <= 1'b0;
`ifdef WB_NOR_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            if (pick1) begin
              state <= GNT1;
              gnt_o <= 2'b10;
            end else begin
              state <= GNT0;
              gnt_o <= 2'b01;
            end
`ifdef WB_NOR_ARB_RR_EN
            last <= pick1;
`endif
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            state <= IDLE;
            gnt_o <= 2'b00;
          end else if (wdog_fire) begin
            state     <= FLUSH;
            gnt_o     <= 2'b00;
            timeout_o <= 1'b1;
            flush_m   <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            state <= IDLE;
            gnt_o <= 2'b00;
          end else if (wdog_fire) begin
            state     <= FLUSH;
            gnt_o     <= 2'b00;
            timeout_o <= 1'b1;
            flush_m   <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_m ? !m1_cyc_i : !m0_cyc_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

  // Bus mux is purely combinational on the registered grant, so reset
  // drops s_cyc_o in the same cycle it is asserted.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_err_o = (state == FLUSH);
    if (g0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_err_o = m0_err_i;
    end else if (g1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_err_o = m1_err_i;
    end
  end

  // An ack landing in the cycle the master drops cyc is swallowed.
  assign m0_ack_o   = g0 & m0_cyc_i & s_ack_i;
  assign m1_ack_o   = g1 & m1_cyc_i & s_ack_i;
  assign m0_stall_o = g0 ? s_stall_i : 1'b1;
  assign m1_stall_o = g1 ? s_stall_i : 1'b1;
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;

  generate
    if (TIMEOUT == 0) begin : g_no_wdog
      assign wdog_fire = 1'b0;
    end else begin : g_wdog
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;
      logic          busy;

      assign busy      = g0 | g1;
      assign wdog_fire = busy & ~s_ack_i & (cnt == LIM);

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          cnt <= '0;
        end else if (!busy || s_ack_i || cnt == LIM) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wb_nor_arbiter.sv
// Self-checking bench for wb_nor_arbiter (watchdog TIMEOUT=8).
`default_nettype none

module tb_wb_nor_arbiter;

  localparam int TMO = 8;
`ifdef WB_NOR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we, err;
  logic [25:0] adr0, adr1;
  logic [15:0] wd0, wd1;
  logic        s_ack, s_stall;
  logic [15:0] s_rd;

  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic [15:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we, s_err;
  logic [25:0] s_adr;
  logic [15:0] s_wd;
  logic [1:0]  gnt;
  logic        tmo;

  int vectors = 0;
  int miscompares = 0;

  wb_nor_arbiter #(.ADDRBITS(26), .DATABITS(16), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_err_i(err[0]),
    .m0_adr_i(adr0), .m0_dat_i(wd0),
    .m0_ack_o(m0_ack), .m0_stall_o(m0_stall), .m0_dat_o(m0_rd),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_err_i(err[1]),
    .m1_adr_i(adr1), .m1_dat_i(wd1),
    .m1_ack_o(m1_ack), .m1_stall_o(m1_stall), .m1_dat_o(m1_rd),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_err_o(s_err),
    .s_adr_o(s_adr), .s_dat_o(s_wd),
    .s_ack_i(s_ack), .s_stall_i(s_stall), .s_dat_i(s_rd),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; err = '0;
    adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
    s_ack = 1'b0; s_stall = 1'b0; s_rd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    s_stall = 1'b0;
    #1;
    vectors++;
    if ({gnt, s_cyc, s_stb, s_we, s_err, tmo} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000000", {gnt, s_cyc, s_stb, s_we, s_err, tmo});
    end
    vectors++;
    if ({s_adr, s_wd} !== 42'b0) begin
      miscompares++;
      $display("FAIL reset_bus got %h want 0", {s_adr, s_wd});
    end
    vectors++;
    if ({m0_ack, m0_stall, m1_ack, m1_stall} !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_resp got %b want 0101", {m0_ack, m0_stall, m1_ack, m1_stall});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr0 = 26'h0001234;
    #1;
    vectors++;
    if (gnt !== 2'b00) begin
      miscompares++;
      $display("FAIL single_pre_gnt got %b want 00", gnt);
    end
    tick();
    vectors++;
    if ({gnt, s_cyc, s_stb} !== 4'b0111) begin
      miscompares++;
      $display("FAIL single_gnt got %b want 0111", {gnt, s_cyc, s_stb});
    end
    vectors++;
    if (s_adr !== 26'h0001234) begin
      miscompares++;
      $display("FAIL single_adr got %h want 0001234", s_adr);
    end
    s_ack = 1'b1; s_rd = 16'hBEEF;
    #1;
    vectors++;
    if ({m0_ack, m0_rd} !== {1'b1, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL single_ack got %b/%h want 1/beef", m0_ack, m0_rd);
    end
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
    tick();
    vectors++;
    if (gnt !== 2'b00) begin
      miscompares++;
      $display("FAIL single_release got %b want 00", gnt);
    end
  endtask

  task automatic test_simultaneous();
    int w;
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      w = RR ? (i % 2) : 0;
      vectors++;
      if (gnt !== (w == 1 ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL simul_gnt%0d got %b want master %0d", i, gnt, w);
      end
      cyc[w] = 1'b0;
      tick();
      vectors++;
      if (gnt !== 2'b00) begin
        miscompares++;
        $display("FAIL simul_idle%0d got %b want 00", i, gnt);
      end
      cyc[w] = 1'b1;
    end
  endtask

  task automatic test_hold();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; s_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({gnt, m0_stall, m1_stall} !== 4'b1010) begin
        miscompares++;
        $display("FAIL hold_%0d got %b want 1010", i, {gnt, m0_stall, m1_stall});
      end
      tick();
    end
    cyc[1] = 1'b0;
    #1;
    vectors++;
    if (s_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_drop got %b want 0", s_cyc);
    end
    tick();
    vectors++;
    if ({gnt, m0_stall} !== 3'b001) begin
      miscompares++;
      $display("FAIL hold_idle got %b want 001", {gnt, m0_stall});
    end
    tick();
    vectors++;
    if ({gnt, m0_stall} !== 3'b010) begin
      miscompares++;
      $display("FAIL hold_m0 got %b want 010", {gnt, m0_stall});
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      #1;
      vectors++;
      if ({gnt, tmo} !== 3'b100) begin
        miscompares++;
        $display("FAIL wdog_wait%0d got %b want 100", i, {gnt, tmo});
      end
      tick();
    end
    s_ack = 1'b1;
    #1;
    vectors++;
    if ({tmo, s_err, s_cyc, gnt, m0_stall, m1_stall, m1_ack} !== 8'b11000110) begin
      miscompares++;
      $display("FAIL wdog_flush got %b want 11000110",
               {tmo, s_err, s_cyc, gnt, m0_stall, m1_stall, m1_ack});
    end
    s_ack = 1'b0;
    tick();
    vectors++;
    if ({tmo, s_err, gnt} !== 4'b0100) begin
      miscompares++;
      $display("FAIL wdog_flush2 got %b want 0100", {tmo, s_err, gnt});
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    vectors++;
    if ({s_err, gnt} !== 3'b000) begin
      miscompares++;
      $display("FAIL wdog_idle got %b want 000", {s_err, gnt});
    end
    tick();
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL wdog_m0 got %b want 01", gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr0 = 26'h0000155; wd0 = 16'hA5A5; s_stall = 1'b1;
    tick();
    vectors++;
    if ({s_cyc, s_we, m0_stall, s_wd} !== {3'b111, 16'hA5A5}) begin
      miscompares++;
      $display("FAIL rmid_write got %b/%h want 111/a5a5", {s_cyc, s_we, m0_stall}, s_wd);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({s_cyc, s_stb, s_we, gnt, m0_stall, tmo, s_adr, s_wd} !== {7'b0000010, 42'b0}) begin
      miscompares++;
      $display("FAIL rmid_reset got %b/%h/%h want 0000010/0/0",
               {s_cyc, s_stb, s_we, gnt, m0_stall, tmo}, s_adr, s_wd);
    end
    cyc = 2'b11; stb = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL rmid_tie got %b want 01", gnt);
    end
  endtask

  task automatic test_err();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    err[0] = 1'b1;
    #1;
    vectors++;
    if (s_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_m0 got %b want 1", s_err);
    end
    err[0] = 1'b0; err[1] = 1'b1; cyc[1] = 1'b1;
    #1;
    vectors++;
    if (s_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_m1 got %b want 0", s_err);
    end
  endtask

  // Reference: who owns the bus, who is being flushed, and how long the
  // owner has gone without an ack.
  task automatic test_random();
    int owner, revoked, quiet, prev;
    bit mto;
    logic [84:0] act, exp_v;
    logic [25:0] e_adr;
    logic [15:0] e_wd;
    logic        e_cyc, e_stb, e_we, e_err;
    logic [1:0]  e_gnt;
    do_reset();
    owner = -1; revoked = -1; quiet = 0; prev = 1; mto = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (cyc[n] && $urandom_range(7) == 0) cyc[n] = 1'b0;
        else if (!cyc[n] && $urandom_range(2) == 0) cyc[n] = 1'b1;
        stb[n] = cyc[n] & 1'($urandom());
        we[n]  = 1'($urandom());
        err[n] = ($urandom_range(15) == 0);
      end
      adr0 = 26'($urandom()); adr1 = 26'($urandom());
      wd0 = 16'($urandom()); wd1 = 16'($urandom());
      s_ack   = (k < 1500) ? 1'($urandom()) : ($urandom_range(7) == 0);
      s_stall = 1'($urandom());
      s_rd    = 16'($urandom());

      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_wd = '0;
      e_err = (revoked >= 0); e_gnt = 2'b00;
      if (owner == 0) begin
        e_cyc = cyc[0]; e_stb = stb[0]; e_we = we[0]; e_adr = adr0; e_wd = wd0;
        e_err = err[0]; e_gnt = 2'b01;
      end else if (owner == 1) begin
        e_cyc = cyc[1]; e_stb = stb[1]; e_we = we[1]; e_adr = adr1; e_wd = wd1;
        e_err = err[1]; e_gnt = 2'b10;
      end
      exp_v = {e_gnt, e_cyc, e_stb, e_we, e_err, e_adr, e_wd,
               (owner == 0) & cyc[0] & s_ack, (owner == 0) ? s_stall : 1'b1,
               (owner == 1) & cyc[1] & s_ack, (owner == 1) ? s_stall : 1'b1,
               mto, s_rd, s_rd};

      @(negedge clk);
      act = {gnt, s_cyc, s_stb, s_we, s_err, s_adr, s_wd,
             m0_ack, m0_stall, m1_ack, m1_stall, tmo, m0_rd, m1_rd};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL random_cycle%0d got %h want %h", k, act, exp_v);
      end

      @(posedge clk);
      mto = 1'b0;
      if (owner >= 0) begin
        if (!cyc[owner]) owner = -1;
        else if (s_ack) quiet = 0;
        else if (quiet == TMO - 1) begin
          revoked = owner; owner = -1; mto = 1'b1; quiet = 0;
        end else quiet++;
      end else if (revoked >= 0) begin
        if (!cyc[revoked]) revoked = -1;
      end else if (cyc != 2'b00) begin
        if (cyc == 2'b11) owner = RR ? 1 - prev : 0;
        else owner = cyc[1] ? 1 : 0;
        prev = owner;
        quiet = 0;
      end
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_hold();
    test_watchdog();
    test_reset_mid();
    test_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_nor_arbiter.md
# wb_nor_arbiter

Two-master Wishbone arbiter that shares the single `nor_bus` driver between the QSPI command path (`wb_nor_controller` master port) and a second on-chip requester (scrub/scan engine). Sits between the masters and `nor_bus`. Grants per Wishbone cycle (`cyc`) and holds the grant until the cycle ends. A watchdog revokes grants from a master whose cycle stops making progress.

## Interface
Parameters:
- `ADDRBITS`, 26, NOR word-address width
- `DATABITS`, 16, NOR data width
- `TIMEOUT`, 1024, max cycles a granted cycle may go without an `ack`; 0 disables watchdog

Ports. One clock; reset is asynchronous and active-high.
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  asynchronous active-high reset
- `m0_cyc_i, m0_stb_i, m0_we_i, m0_err_i`  in  1 each  master 0 (QSPI path) control; `err_i` is the master abort, as on `nor_bus`
- `m0_adr_i`  in  ADDRBITS  master 0 address
- `m0_dat_i`  in  DATABITS  master 0 write data
- `m0_ack_o, m0_stall_o`  out  1 each  master 0 response
- `m0_dat_o`  out  DATABITS  master 0 read data
- `m1_*`  same set as m0  master 1 (scrubber)
- `s_cyc_o, s_stb_o, s_we_o, s_err_o`  out  1 each  to `nor_bus`
- `s_adr_o`  out  ADDRBITS  to `nor_bus`
- `s_dat_o`  out  DATABITS  to `nor_bus`
- `s_ack_i, s_stall_i`  in  1 each  from `nor_bus`
- `s_dat_i`  in  DATABITS  from `nor_bus`
- `gnt_o`  out  2  one-hot current grant; debug
- `timeout_o`  out  1  one-cycle pulse on watchdog revoke

## Operation
- FSM states:
  - IDLE, GNT0, GNT1: grant decision.
  - FLUSH: wait for the revoked master to drop `cyc`.
- IDLE:
  - If any `mN_cyc_i` is high, register the winner and enter GNTn.
  - Winner rule is set by the arbitration mode (see Configuration).
- GNTn:
  - `s_*` outputs are combinational muxes of master n, gated by the registered grant.
  - `mn_ack_o = s_ack_i`; `mn_stall_o = s_stall_i`.
- Non-granted master: `stall_o=1`, `ack_o=0`. Both masters see `mN_dat_o = s_dat_i`.
- Grant release:
  - GNTn → IDLE when `mn_cyc_i` is low (abort or normal end).
  - An outstanding `ack` in the release cycle is dropped. Masters must not drop `cyc` with requests pending unless aborting.
- Watchdog:
  - Counter clears on grant change and on each `s_ack_i`.
  - Counter increments every GNTn cycle without `s_ack_i`.
  - At count == TIMEOUT-1 with no ack: next edge enters FLUSH and pulses `timeout_o`.
  - FLUSH drives `s_cyc_o=0`, `s_stb_o=0` and `s_err_o=1`, aborting `nor_bus`.
  - The revoked master sees `stall_o=1`, `ack_o=0`.
- FLUSH → IDLE when the revoked master's `cyc` is low. The other master is not granted until then.
- `mN_err_i` passes through to `s_err_o` only while granted.
- Round-robin pointer `last` holds the most recently granted master. It updates on every entry to GNTn.

## Timing
- Reset values:
  - state IDLE, `gnt_o=0`, `last=1` (master 0 wins first tie), counter 0.
  - `s_cyc_o=s_stb_o=s_we_o=s_err_o=0`, `s_adr_o=0`, `s_dat_o=0`.
  - `mN_ack_o=0`, `mN_stall_o=1`, `timeout_o=0`.
- Arbitration latency: `cyc` rising in cycle k gives a grant at edge k+1, and `s_cyc_o/s_stb_o` follow in cycle k+1.
- No added latency on the data path once granted; ack/stall/data are combinational.
- Minimum one IDLE cycle between grants, so back-to-back cycles from different masters are separated by one bubble.
- Reset asserted mid-cycle: outputs go to reset values immediately (asynchronous). `nor_bus` sees `cyc` drop.
- Simultaneous requests in IDLE: resolved by the arbitration mode; exactly one grant.
- `TIMEOUT=0`: counter logic is removed and FLUSH is unreachable.

## Configuration
- `WB_NOR_ARB_RR_EN` defined: round-robin. A tie is won by the master ≠ `last`; a lone requester always wins.
- Not defined: fixed priority. Master 0 wins every tie; `last` is unused.

## Test plan
- Single request: m0 reads addr 0x0001234 while m1 is idle → `gnt_o=01` one cycle after `cyc`. `s_adr_o=0x0001234`, and `m0_dat_o` returns the `nor_bus` data with the ack.
- Simultaneous `cyc` from both masters, repeated 4 times:
  - RR build: grants alternate m0, m1, m0, m1.
  - Fixed build: all four go to m0 while m0 re-requests immediately.
- m1 holds the grant while m0 requests → `m0_stall_o=1` throughout. m1 drops `cyc` at cycle t → IDLE at t+1, m0 granted at t+2.
- Watchdog with TIMEOUT=8: m1 granted and `s_ack_i` held low → `timeout_o` pulses after 8 ack-less cycles, `s_err_o=1` in FLUSH, m0 still blocked. m1 drops `cyc` → IDLE, then m0 is granted.
- Reset pulsed during a m0 write with `s_stall_i=1` → all outputs at reset values in the same cycle; the first grant after release goes to m0 on a tie.
- m0 asserts `m0_err_i` mid-cycle → `s_err_o=1` the same cycle. m1's `err` while not granted → `s_err_o` stays 0.
